// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage cache controller: address map,
// cache field widths, FSM encoding and the latched request payload.
package mem_pkg;

    localparam int unsigned DATA_BASE = 1024;
    localparam int unsigned TAG_W     = 10;
    localparam int unsigned IDX_W     = 6;
    // Word address into cache/SRAM: {tag, index, offset}
    localparam int unsigned ADDR_W    = TAG_W + IDX_W + 1;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned LINE_W    = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR      = 2'd2
    } state_e;

    // Request captured when a miss or store is accepted
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/cache_controller.sv
// Cache controller between the MEM stage and the 2-way data cache / SRAM
// controller. Read hits complete in the same cycle; read misses fetch a
// 64-bit line from SRAM and fill the cache; stores are write-through,
// no-write-allocate and drop the cached line. ready=0 freezes the pipeline.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   mem_r_en/mem_w_en        MEM stage load/store request
//   mem_addr/mem_wdata       byte address / store data
//   mem_rdata, ready         load data (combinational), pipeline stall
//   cache_addr               translated word address {tag, index, offset}
//   cache_rdata, cache_hit   combinational cache lookup result
//   cache_read_en            read-hit pulse (LRU update)
//   cache_write_en           line-fill pulse, data on cache_wdata
//   cache_invalid            store pulse, drops the line on a hit
//   sram_addr/sram_wdata     SRAM word address / store data
//   sram_re/sram_we          SRAM line read / word write, held until sram_ready
//   sram_rdata, sram_ready   SRAM line data / one-cycle completion
//   hit_count/miss_count     saturating read hit/miss counters
module cache_controller #(
    parameter int unsigned DATA_BASE = mem_pkg::DATA_BASE,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_r_en,
    input  logic                       mem_w_en,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    output logic [31:0]                mem_rdata,
    output logic                       ready,
    output logic [mem_pkg::ADDR_W-1:0] cache_addr,
    input  logic [31:0]                cache_rdata,
    input  logic                       cache_hit,
    output logic                       cache_read_en,
    output logic                       cache_write_en,
    output logic                       cache_invalid,
    output logic [63:0]                cache_wdata,
    output logic [mem_pkg::ADDR_W-1:0] sram_addr,
    output logic [31:0]                sram_wdata,
    output logic                       sram_re,
    output logic                       sram_we,
    input  logic [63:0]                sram_rdata,
    input  logic                       sram_ready,
    output logic [CNT_W-1:0]           hit_count,
    output logic [CNT_W-1:0]           miss_count
);

    import mem_pkg::ADDR_W;
    import mem_pkg::state_e;
    import mem_pkg::IDLE;
    import mem_pkg::RD_MISS;
    import mem_pkg::WR;
    import mem_pkg::req_t;

    state_e state_q, state_d;
    req_t   req_q;
    logic   latch_en;
    logic   hit_inc;
    logic   miss_inc;
    logic   rd_req;
    logic   wr_req;

    // Byte address to word address relative to the data segment
    logic [31:0] word_addr;
    logic        unused_word_hi;
    assign word_addr      = (mem_addr - 32'(DATA_BASE)) >> 2;
    assign cache_addr     = word_addr[ADDR_W-1:0];
    assign unused_word_hi = ^word_addr[31:ADDR_W];

    // Requests are ignored while reset is held so every output shows its reset value
    assign rd_req = rst & mem_r_en;
    assign wr_req = rst & mem_w_en;

    // State, latched request and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_q <= state_d;
            if (latch_en) begin
                req_q.addr  <= cache_addr;
                req_q.wdata <= mem_wdata;
            end
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_d        = state_q;
        ready          = 1'b1;
        mem_rdata      = '0;
        cache_read_en  = 1'b0;
        cache_write_en = 1'b0;
        cache_invalid  = 1'b0;
        cache_wdata    = '0;
        sram_addr      = '0;
        sram_wdata     = '0;
        sram_re        = 1'b0;
        sram_we        = 1'b0;
        latch_en       = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Store wins over a simultaneous load
                if (wr_req) begin
                    latch_en      = 1'b1;
                    cache_invalid = 1'b1;
                    ready         = 1'b0;
                    state_d       = WR;
                end else if (rd_req) begin
                    if (cache_hit) begin
                        mem_rdata     = cache_rdata;
                        cache_read_en = 1'b1;
                        hit_inc       = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                        miss_inc = 1'b1;
                        ready    = 1'b0;
                        state_d  = RD_MISS;
                    end
                end
            end

            RD_MISS: begin
                // Fetch the whole line, so the offset bit is cleared
                sram_re   = 1'b1;
                sram_addr = {req_q.addr[ADDR_W-1:1], 1'b0};
                ready     = 1'b0;
                if (sram_ready) begin
                    cache_write_en = 1'b1;
                    cache_wdata    = sram_rdata;
                    mem_rdata      = req_q.addr[0] ? sram_rdata[63:32] : sram_rdata[31:0];
                    ready          = 1'b1;
                    state_d        = IDLE;
                end
            end

            WR: begin
                sram_we    = 1'b1;
                sram_addr  = req_q.addr;
                sram_wdata = req_q.wdata;
                ready      = 1'b0;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed loads/stores against a
// one-line cache model, with a scoreboard queue checked by a monitor on
// every completed transaction.
module tb_cache_controller;

    typedef enum logic [1:0] {K_HIT, K_FILL, K_STORE} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] rdata;
        logic [63:0] line;
        logic [16:0] saddr;
        logic [31:0] swdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        ready;
    logic [16:0] cache_addr, sram_addr;
    logic [31:0] cache_rdata, sram_wdata;
    logic        cache_hit, cache_read_en, cache_write_en, cache_invalid;
    logic [63:0] cache_wdata, sram_rdata;
    logic        sram_re, sram_we, sram_ready;
    logic [15:0] hit_count, miss_count;

    // Small-counter instance used to reach saturation quickly
    logic        s_r_en;
    logic [31:0] s_rdata, s_sram_wdata;
    logic        s_ready, s_rd_en, s_wr_en, s_inv, s_re, s_we;
    logic [16:0] s_cache_addr, s_sram_addr;
    logic [63:0] s_cache_wdata;
    logic [2:0]  s_hit_count, s_miss_count;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ready(ready), .cache_addr(cache_addr),
        .cache_rdata(cache_rdata), .cache_hit(cache_hit),
        .cache_read_en(cache_read_en), .cache_write_en(cache_write_en),
        .cache_invalid(cache_invalid), .cache_wdata(cache_wdata),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_re(sram_re), .sram_we(sram_we),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    cache_controller #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst),
        .mem_r_en(s_r_en), .mem_w_en(1'b0),
        .mem_addr(32'd1024), .mem_wdata(32'd0), .mem_rdata(s_rdata),
        .ready(s_ready), .cache_addr(s_cache_addr),
        .cache_rdata(32'h5A5A_0000), .cache_hit(1'b1),
        .cache_read_en(s_rd_en), .cache_write_en(s_wr_en),
        .cache_invalid(s_inv), .cache_wdata(s_cache_wdata),
        .sram_addr(s_sram_addr), .sram_wdata(s_sram_wdata),
        .sram_re(s_re), .sram_we(s_we),
        .sram_rdata(64'd0), .sram_ready(1'b0),
        .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    // One-line cache model: filled by cache_write_en, dropped by cache_invalid on a hit
    logic        line_v;
    logic [15:0] line_tag;
    logic [63:0] line_d;
    assign cache_hit   = line_v && (line_tag == cache_addr[16:1]);
    assign cache_rdata = cache_addr[0] ? line_d[63:32] : line_d[31:0];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_v   <= 1'b0;
            line_tag <= '0;
            line_d   <= '0;
        end else if (cache_write_en) begin
            line_v   <= 1'b1;
            line_tag <= sram_addr[16:1];
            line_d   <= cache_wdata;
        end else if (cache_invalid && cache_hit) begin
            line_v <= 1'b0;
        end
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input kind_e k, input logic [31:0] rd, input logic [63:0] ln,
                        input logic [16:0] sa, input logic [31:0] sw);
        exp_t e;
        e.kind   = k;
        e.rdata  = rd;
        e.line   = ln;
        e.saddr  = sa;
        e.swdata = sw;
        exp_q.push_back(e);
    endtask

    // Monitor: a transaction completes when a request is held and ready is high
    always @(negedge clk) begin
        if (rst && (mem_r_en || mem_w_en) && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got addr %h expected no transaction", mem_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_read_en", 64'(cache_read_en), 64'(e.kind == K_HIT));
                chk("mon_write_en", 64'(cache_write_en), 64'(e.kind == K_FILL));
                chk("mon_invalid", 64'(cache_invalid), 64'd0);
                if (e.kind == K_STORE) begin
                    chk("mon_sram_we", 64'(sram_we), 64'd1);
                    chk("mon_sram_addr", 64'(sram_addr), 64'(e.saddr));
                    chk("mon_sram_wdata", 64'(sram_wdata), 64'(e.swdata));
                end else begin
                    chk("mon_rdata", 64'(mem_rdata), 64'(e.rdata));
                    if (e.kind == K_FILL) begin
                        chk("mon_fill_line", cache_wdata, e.line);
                        chk("mon_fill_addr", 64'(sram_addr), 64'(e.saddr));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; mem_addr = 32'd1024;
        mem_wdata = '0; sram_rdata = '0; sram_ready = 1'b0; s_r_en = 1'b0;

        // 1. reset and idle
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_sram_re", 64'(sram_re), 64'd0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(ready), 64'd1);
        chk("idle_strobes", 64'({cache_read_en, cache_write_en, cache_invalid, sram_re, sram_we}), 64'd0);
        chk("idle_hit_count", 64'(hit_count), 64'd0);
        chk("idle_miss_count", 64'(miss_count), 64'd0);
        chk("idle_rdata", 64'(mem_rdata), 64'd0);

        // Address translation, including wrap of the ignored upper bits
        mem_addr = 32'd1024;   #1 chk("xlat_base", 64'(cache_addr), 64'd0);
        mem_addr = 32'd1020;   #1 chk("xlat_below", 64'(cache_addr), 64'h1FFFF);
        mem_addr = 32'd525320; #1 chk("xlat_wrap", 64'(cache_addr), 64'd2);

        // 2. cold read miss at 1032 (word 2)
        step();
        mem_addr = 32'd1032; mem_r_en = 1'b1;
        push(K_FILL, 32'hAAAA_0000, 64'hBBBB_0001_AAAA_0000, 17'd2, '0);
        @(negedge clk);
        chk("miss_ready0", 64'(ready), 64'd0);
        chk("miss_cache_addr", 64'(cache_addr), 64'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("miss_sram_re", 64'(sram_re), 64'd1);
            chk("miss_sram_addr", 64'(sram_addr), 64'd2);
            chk("miss_stall", 64'(ready), 64'd0);
        end
        chk("miss_count1", 64'(miss_count), 64'd1);
        step();
        sram_ready = 1'b1; sram_rdata = 64'hBBBB_0001_AAAA_0000;
        @(negedge clk);
        step();
        sram_ready = 1'b0; mem_r_en = 1'b0;
        @(negedge clk);
        chk("after_fill_re", 64'(sram_re), 64'd0);
        chk("after_fill_wr_en", 64'(cache_write_en), 64'd0);

        // 3. read hit at 1036 (word 3, upper half of the filled line)
        step();
        mem_addr = 32'd1036; mem_r_en = 1'b1;
        push(K_HIT, 32'hBBBB_0001, '0, '0, '0);
        @(negedge clk);
        step();
        mem_r_en = 1'b0;
        @(negedge clk);
        chk("hit_count1", 64'(hit_count), 64'd1);
        chk("hit_miss_count", 64'(miss_count), 64'd1);

        // 4. store at 1032
        step();
        mem_addr = 32'd1032; mem_wdata = 32'h1234; mem_w_en = 1'b1;
        push(K_STORE, '0, '0, 17'd2, 32'h1234);
        @(negedge clk);
        chk("st_invalid", 64'(cache_invalid), 64'd1);
        chk("st_ready0", 64'(ready), 64'd0);
        chk("st_we_early", 64'(sram_we), 64'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            chk("st_invalid_once", 64'(cache_invalid), 64'd0);
            chk("st_sram_we", 64'(sram_we), 64'd1);
            chk("st_sram_addr", 64'(sram_addr), 64'd2);
            chk("st_sram_wdata", 64'(sram_wdata), 64'h1234);
            chk("st_stall", 64'(ready), 64'd0);
            chk("st_no_fill", 64'(cache_write_en), 64'd0);
        end
        step();
        sram_ready = 1'b1;
        @(negedge clk);
        step();
        sram_ready = 1'b0; mem_w_en = 1'b0;
        @(negedge clk);
        chk("st_line_dropped", 64'(line_v), 64'd0);
        chk("st_done_we", 64'(sram_we), 64'd0);

        // 5. simultaneous load and store behaves as a store
        step();
        mem_addr = 32'd1036; mem_wdata = 32'hCAFE; mem_r_en = 1'b1; mem_w_en = 1'b1;
        push(K_STORE, '0, '0, 17'd3, 32'hCAFE);
        @(negedge clk);
        chk("both_invalid", 64'(cache_invalid), 64'd1);
        chk("both_no_read_en", 64'(cache_read_en), 64'd0);
        step();
        @(negedge clk);
        chk("both_sram_we", 64'(sram_we), 64'd1);
        chk("both_no_sram_re", 64'(sram_re), 64'd0);
        step();
        sram_ready = 1'b1;
        @(negedge clk);
        step();
        sram_ready = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        @(negedge clk);
        chk("both_miss_count", 64'(miss_count), 64'd1);
        chk("both_hit_count", 64'(hit_count), 64'd1);

        // 6. reset in the middle of a read miss
        step();
        mem_addr = 32'd1040; mem_r_en = 1'b1;
        step();
        @(negedge clk);
        chk("abort_sram_re", 64'(sram_re), 64'd1);
        chk("abort_sram_addr", 64'(sram_addr), 64'd4);
        chk("abort_miss_count", 64'(miss_count), 64'd2);
        #2 rst = 1'b0; mem_r_en = 1'b0;
        #1;
        chk("abort_re_drop", 64'(sram_re), 64'd0);
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_count_clr", 64'(miss_count), 64'd0);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(ready), 64'd1);
        chk("post_rst_strobes", 64'({sram_re, sram_we, cache_write_en}), 64'd0);

        // Counter saturation on the 3-bit instance
        step();
        s_r_en = 1'b1;
        repeat (7) step();
        @(negedge clk);
        chk("sat_reach_max", 64'(s_hit_count), 64'd7);
        chk("sat_rdata", 64'(s_rdata), 64'h5A5A_0000);
        chk("sat_read_en", 64'(s_rd_en), 64'd1);
        repeat (3) step();
        @(negedge clk);
        chk("sat_hold_max", 64'(s_hit_count), 64'd7);
        chk("sat_main_untouched", 64'(hit_count), 64'd0);
        s_r_en = 1'b0;

        step();
        step();
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
